// File: rtl/pong_ball_ctrl_if.sv
// Signal bundle between the ball controller and the rest of the Pong datapath
// (collision detector inputs, ball position, scores and rally status).
interface pong_ball_ctrl_if;
   logic       start;
   logic [1:0] paddle_collision;
   logic       wall_collision;
   logic [5:0] bx;
   logic [5:0] by;
   logic       dx;
   logic       dy;
   logic [2:0] sc1;
   logic [2:0] sc2;
   logic       point_p1;
   logic       point_p2;
   logic       game_over;
   logic [2:0] state;

   modport master (
      input  start, paddle_collision, wall_collision,
      output bx, by, dx, dy, sc1, sc2, point_p1, point_p2, game_over, state
   );

   modport slave (
      output start, paddle_collision, wall_collision,
      input  bx, by, dx, dy, sc1, sc2, point_p1, point_p2, game_over, state
   );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: moves the ball once per tick, bounces it off paddles
// and walls, detects misses, keeps scores and sequences serve/play/point.
module pong_ball_ctrl #(
   parameter int TICK_DIV    = 4,
   parameter int SERVE_TICKS = 8,
   parameter int WIN_SCORE   = 7,
   parameter int P1_X        = 2,
   parameter int P2_X        = 61
) (
   input logic              clk,
   input logic              rst,
   pong_ball_ctrl_if.master bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
   localparam logic [5:0]    P1_COL     = 6'(P1_X);
   localparam logic [5:0]    P2_COL     = 6'(P2_X);
   localparam logic [5:0]    CENTRE     = 6'd32;
   localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      POINT     = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [SW-1:0]   serve_q, serve_d;
   logic [5:0]      bx_q, bx_d, by_q, by_d;
   logic            dx_q, dx_d, dy_q, dy_d;
   logic [2:0]      sc1_q, sc1_d, sc2_q, sc2_d;
   logic            point_p1_q, point_p1_d, point_p2_q, point_p2_d;
   logic            step;
   logic            dx_new, dy_new;
   logic [2:0]      sc1_inc, sc2_inc;

   assign step    = (tick_q == TICK_LAST);
   assign sc1_inc = (sc1_q == 3'd7) ? 3'd7 : sc1_q + 3'd1;
   assign sc2_inc = (sc2_q == 3'd7) ? 3'd7 : sc2_q + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         serve_q    <= '0;
         bx_q       <= CENTRE;
         by_q       <= CENTRE;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         sc1_q      <= '0;
         sc2_q      <= '0;
         point_p1_q <= 1'b0;
         point_p2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         serve_q    <= serve_d;
         bx_q       <= bx_d;
         by_q       <= by_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         sc1_q      <= sc1_d;
         sc2_q      <= sc2_d;
         point_p1_q <= point_p1_d;
         point_p2_q <= point_p2_d;
      end
   end

   // Point pulses are registered on the miss, so they are high exactly while in POINT
   // and also tell POINT which player scored.
   always_comb begin
      tick_d     = step ? '0 : tick_q + TW'(1);
      state_d    = state_q;
      serve_d    = serve_q;
      bx_d       = bx_q;
      by_d       = by_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      sc1_d      = sc1_q;
      sc2_d      = sc2_q;
      point_p1_d = 1'b0;
      point_p2_d = 1'b0;
      dx_new     = dx_q;
      dy_new     = dy_q;

      case (state_q)
         IDLE, GAME_OVER: begin
            if (bus.start) begin
               sc1_d   = '0;
               sc2_d   = '0;
               dx_d    = 1'b1;
               dy_d    = 1'b1;
               serve_d = '0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (step) begin
               if (serve_q == SERVE_LAST) state_d = PLAY;
               else                       serve_d = serve_q + SW'(1);
            end
         end
         PLAY: begin
            if (step) begin
               if (bx_q == P1_COL && !dx_q && bus.paddle_collision != 2'b01) begin
                  point_p2_d = 1'b1;
                  state_d    = POINT;
               end else if (bx_q == P2_COL && dx_q && bus.paddle_collision != 2'b11) begin
                  point_p1_d = 1'b1;
                  state_d    = POINT;
               end else begin
                  if (bus.paddle_collision == 2'b01 && !dx_q) dx_new = 1'b1;
                  if (bus.paddle_collision == 2'b11 && dx_q)  dx_new = 1'b0;
                  if (bus.wall_collision) begin
                     if (by_q == 6'd0)       dy_new = 1'b1;
                     else if (by_q == 6'd63) dy_new = 1'b0;
                  end
                  dx_d = dx_new;
                  dy_d = dy_new;
                  bx_d = dx_new ? bx_q + 6'd1 : bx_q - 6'd1;
                  by_d = dy_new ? by_q + 6'd1 : by_q - 6'd1;
               end
            end
         end
         POINT: begin
            bx_d    = CENTRE;
            by_d    = CENTRE;
            serve_d = '0;
            // Serve goes toward whoever conceded the point.
            if (point_p1_q) begin
               sc1_d   = sc1_inc;
               dx_d    = 1'b1;
               state_d = (sc1_inc == WIN) ? GAME_OVER : SERVE;
            end else begin
               sc2_d   = sc2_inc;
               dx_d    = 1'b0;
               state_d = (sc2_inc == WIN) ? GAME_OVER : SERVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.bx        = bx_q;
   assign bus.by        = by_q;
   assign bus.dx        = dx_q;
   assign bus.dy        = dy_q;
   assign bus.sc1       = sc1_q;
   assign bus.sc2       = sc2_q;
   assign bus.point_p1  = point_p1_q;
   assign bus.point_p2  = point_p2_q;
   assign bus.game_over = (state_q == GAME_OVER);
   assign bus.state     = state_q;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: a ball/score model acts as the collision detector
// and is compared against the controller every cycle, plus literal spot checks.
module tb_pong_ball_ctrl;
   localparam int TICK_DIV    = 2;
   localparam int SERVE_TICKS = 2;
   localparam int WIN_SCORE   = 2;
   localparam int P1_X        = 2;
   localparam int P2_X        = 61;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pong_ball_ctrl_if bus();

   pong_ball_ctrl #(
      .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS), .WIN_SCORE(WIN_SCORE),
      .P1_X(P1_X), .P2_X(P2_X)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 1'b0;
   int mode       = 1;

   // Model: state as plain numbers, velocities as +1/-1.
   int mstate = 0, mtick = 0, mserves = 0;
   int mbx = 32, mby = 32, mvx = 1, mvy = 1;
   int msc1 = 0, msc2 = 0;
   bit mp1 = 1'b0, mp2 = 1'b0;

   logic [1:0] pc_v;
   logic       wall_v;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r);
      bus.start = s;
      rst       = r;
      @(negedge clk);
   endtask

   function automatic int satInc(input int v);
      return (v >= 7) ? 7 : v + 1;
   endfunction

   task automatic modelStep();
      bit stp;
      int scorer;
      bit missed;
      if (rst) begin
         mstate = 0; mtick = 0; mserves = 0;
         mbx = 32; mby = 32; mvx = 1; mvy = 1;
         msc1 = 0; msc2 = 0; mp1 = 0; mp2 = 0;
         return;
      end
      stp    = (mtick == TICK_DIV - 1);
      mtick  = (mtick + 1) % TICK_DIV;
      scorer = mp1 ? 1 : (mp2 ? 2 : 0);
      mp1    = 0;
      mp2    = 0;
      case (mstate)
         0, 4: if (bus.start) begin
            msc1 = 0; msc2 = 0; mvx = 1; mvy = 1; mserves = 0; mstate = 1;
         end
         1: if (stp) begin
            mserves++;
            if (mserves >= SERVE_TICKS) mstate = 2;
         end
         2: if (stp) begin
            missed = 0;
            if (mbx == P1_X && mvx < 0 && bus.paddle_collision != 2'b01) begin
               mp2 = 1; missed = 1;
            end else if (mbx == P2_X && mvx > 0 && bus.paddle_collision != 2'b11) begin
               mp1 = 1; missed = 1;
            end
            if (missed) mstate = 3;
            else begin
               if (bus.paddle_collision == 2'b01 && mvx < 0) mvx = 1;
               if (bus.paddle_collision == 2'b11 && mvx > 0) mvx = -1;
               if (bus.wall_collision && mby == 0)  mvy = 1;
               if (bus.wall_collision && mby == 63) mvy = -1;
               mbx += mvx;
               mby += mvy;
            end
         end
         3: begin
            mbx = 32; mby = 32; mserves = 0;
            if (scorer == 1) begin
               msc1 = satInc(msc1); mvx = 1;
               mstate = (msc1 == WIN_SCORE) ? 4 : 1;
            end else begin
               msc2 = satInc(msc2); mvx = -1;
               mstate = (msc2 == WIN_SCORE) ? 4 : 1;
            end
         end
         default: mstate = 0;
      endcase
   endtask

   always @(posedge clk) modelStep();

   // Compare against the model, then play the collision detector for the next edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("bx", bus.bx, mbx);
         checkOutput("by", bus.by, mby);
         checkOutput("dx", bus.dx, (mvx > 0) ? 1 : 0);
         checkOutput("dy", bus.dy, (mvy > 0) ? 1 : 0);
         checkOutput("sc1", bus.sc1, msc1);
         checkOutput("sc2", bus.sc2, msc2);
         checkOutput("point_p1", bus.point_p1, mp1);
         checkOutput("point_p2", bus.point_p2, mp2);
         checkOutput("game_over", bus.game_over, (mstate == 4) ? 1 : 0);
         checkOutput("state", bus.state, mstate);
      end
      pc_v   = 2'b00;
      wall_v = (mby == 0 || mby == 63);
      if (mode != 1) begin
         if (mbx == P1_X && mvx < 0 && (mode == 2 || $urandom_range(0, 3) != 0)) pc_v = 2'b01;
         if (mbx == P2_X && mvx > 0 && (mode == 2 || $urandom_range(0, 3) != 0)) pc_v = 2'b11;
      end
      if (mode == 0) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
               0:       pc_v = 2'b00;
               1:       pc_v = 2'b01;
               default: pc_v = 2'b11;
            endcase
         end
         if ($urandom_range(0, 15) == 0) wall_v = 1'b1;
      end
      bus.paddle_collision = pc_v;
      bus.wall_collision   = wall_v;
   end

   initial begin
      int n;
      bus.start            = 1'b0;
      bus.paddle_collision = 2'b00;
      bus.wall_collision   = 1'b0;

      repeat (3) applyStimulus(1'b0, 1'b1);
      chk_en = 1'b1;
      repeat (20) applyStimulus(1'b0, 1'b0);
      checkOutput("idle_bx", bus.bx, 32);
      checkOutput("idle_by", bus.by, 32);
      checkOutput("idle_sc1", bus.sc1, 0);
      checkOutput("idle_sc2", bus.sc2, 0);
      checkOutput("idle_state", bus.state, 0);
      checkOutput("idle_points", {bus.point_p1, bus.point_p2}, 0);

      mode = 1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("start_state", bus.state, 1);
      bus.start = 1'b0;
      n = 0;
      while (bus.state != 3'd2 && n < 20) begin @(negedge clk); n++; end
      checkOutput("reach_play", bus.state, 2);
      n = 0;
      while (bus.bx == 6'd32 && n < 8) begin @(negedge clk); n++; end
      checkOutput("first_step_bx", bus.bx, 33);
      checkOutput("first_step_by", bus.by, 33);
      n = 0;
      while (bus.bx == 6'd33 && n < 8) begin @(negedge clk); n++; end
      checkOutput("second_step_bx", bus.bx, 34);
      checkOutput("second_step_by", bus.by, 34);

      // P2 never returns: P1 scores twice and the game ends.
      n = 0;
      while (!bus.point_p1 && n < 400) begin @(negedge clk); n++; end
      checkOutput("p1_pulse", bus.point_p1, 1);
      checkOutput("p1_pulse_state", bus.state, 3);
      @(negedge clk);
      checkOutput("after_point_sc1", bus.sc1, 1);
      checkOutput("after_point_bx", bus.bx, 32);
      checkOutput("after_point_by", bus.by, 32);
      checkOutput("after_point_dx", bus.dx, 1);
      checkOutput("after_point_state", bus.state, 1);
      checkOutput("after_point_pulse", bus.point_p1, 0);
      n = 0;
      while (!bus.point_p1 && n < 400) begin @(negedge clk); n++; end
      checkOutput("p1_pulse2", bus.point_p1, 1);
      @(negedge clk);
      repeat (10) @(negedge clk);
      checkOutput("gameover_state", bus.state, 4);
      checkOutput("gameover_flag", bus.game_over, 1);
      checkOutput("gameover_sc1", bus.sc1, 2);
      checkOutput("gameover_bx", bus.bx, 32);
      applyStimulus(1'b1, 1'b0);
      checkOutput("restart_state", bus.state, 1);
      checkOutput("restart_sc1", bus.sc1, 0);
      checkOutput("restart_dx", bus.dx, 1);
      bus.start = 1'b0;

      mode = 2;
      repeat (1500) applyStimulus(1'b0, 1'b0);

      mode = 0;
      for (int i = 0; i < 6000; i++) applyStimulus($urandom_range(0, 7) == 0, 1'b0);

      n = 0;
      while (mstate != 2 && n < 2000) begin
         applyStimulus($urandom_range(0, 3) == 0, 1'b0);
         n++;
      end
      checkOutput("reach_play_for_reset", mstate, 2);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rst_state", bus.state, 0);
      checkOutput("rst_bx", bus.bx, 32);
      checkOutput("rst_by", bus.by, 32);
      checkOutput("rst_dirs", {bus.dx, bus.dy}, 3);
      checkOutput("rst_scores", {bus.sc1, bus.sc2}, 0);
      checkOutput("rst_flags", {bus.point_p1, bus.point_p2, bus.game_over}, 0);
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
Ball motion and rally controller for the Pong datapath. It owns the ball position (bx, by) and direction, and drives the collision detector with that position. It consumes the detector's paddle_collision and wall_collision flags to bounce the ball, detects misses, and keeps the player scores. It also sequences the game through idle, serve, play, point and game-over states.

Parameters:
TICK_DIV, 4, clock cycles per ball step (>=1)
SERVE_TICKS, 8, ball steps the ball is held at centre before each serve
WIN_SCORE, 7, score that ends the game (1..7)
P1_X, 2, column of the left paddle face
P2_X, 61, column of the right paddle face

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  level; starts a game from IDLE or GAME_OVER
paddle_collision  input  2  from the detector: 01 = left paddle hit, 11 = right paddle hit, 00 = none
wall_collision  input  1  from the detector: ball on row 0 or row 63
bx  output  6  ball column
by  output  6  ball row
dx  output  1  1 = moving right (+1), 0 = moving left (-1)
dy  output  1  1 = moving down (+1), 0 = moving up (-1)
sc1  output  3  player 1 score
sc2  output  3  player 2 score
point_p1  output  1  one-cycle pulse when player 1 scores
point_p2  output  1  one-cycle pulse when player 2 scores
game_over  output  1  high while in GAME_OVER
state  output  3  current state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, bx=32, by=32, dx=1, dy=1, sc1=0, sc2=0, point_p1=0, point_p2=0, game_over=0, tick counter=0, serve counter=0. Reset takes priority over every other input in any state, including mid-rally.
- Tick counter: free-running from 0 to TICK_DIV-1, then wraps to 0.
  - step = (counter == TICK_DIV-1).
  - All ball and serve actions happen only on step cycles. Outputs are registered and change on the edge that ends the step cycle.
- IDLE: ball held at (32,32). When start=1 (sampled any cycle): clear sc1 and sc2, set dx=1 and dy=1, clear the serve counter, go to SERVE.
- SERVE: ball held at (32,32).
  - The serve counter increments on each step.
  - On the step where the count reaches SERVE_TICKS-1, go to PLAY.
  - start is ignored in this state.
- PLAY, on each step, evaluated at the current position in this order:
  1. Miss check.
     - If bx==P1_X and dx==0 and paddle_collision!=01: player 2 scores; go to POINT; the ball does not move.
     - If bx==P2_X and dx==1 and paddle_collision!=11: player 1 scores; go to POINT; the ball does not move.
  2. Paddle bounce.
     - paddle_collision==01 with dx==0 sets dx=1.
     - paddle_collision==11 with dx==1 sets dx=0.
     - A paddle flag that does not match the current direction is ignored.
  3. Wall bounce. When wall_collision=1: by==0 forces dy=1; by==63 forces dy=0.
  4. Step. bx += (dx ? +1 : -1) and by += (dy ? +1 : -1), using the updated directions.
- Simultaneous paddle and wall flags on the same step: both bounces apply in the same step (corner bounce).
- Range guarantee: bx and by never wrap. Rows 0 and 63 are always reflected before the step is taken.
- POINT (lasts exactly 1 cycle, not tied to step):
  - Increment the scoring player's score, saturating at 7.
  - Assert the matching point_pX for exactly this cycle.
  - Recentre the ball to (32,32).
  - Set dx toward the player who conceded (P1 conceded -> dx=0; P2 conceded -> dx=1). Keep dy unchanged.
  - Clear the serve counter.
  - Next state: GAME_OVER if the new score == WIN_SCORE, otherwise SERVE.
- GAME_OVER: game_over=1; scores and ball are frozen. When start=1: clear the scores, set dx=1 and dy=1, go to SERVE.
- start in PLAY or POINT: ignored.
- Collision inputs: treated as combinational functions of the current bx and by. They are sampled only on step cycles in PLAY.

Test Plan:
1. Reset, then 20 idle cycles -> bx=32, by=32, sc1=0, sc2=0, state=0, no point pulses.
2. TICK_DIV=2, SERVE_TICKS=2, start=1 -> state goes 1 then 2 after 2 steps. The ball then moves (+1,+1) every 2 cycles: (33,33), (34,34).
3. Force by=1 with dy=0, step to by=0, drive wall_collision=1 -> next step gives dy=1 and by=1; by never shows 63.
4. Ball at bx=2, dx=0, paddle_collision=01 -> dx=1, bx=3, no point pulse. Repeat with paddle_collision=00 -> point_p2 pulses for 1 cycle, sc2 becomes 1, ball at (32,32), dx=0, state=SERVE.
5. Corner case: ball at bx=61, by=63, dx=1, dy=1, with paddle_collision=11 and wall_collision=1 -> dx=0, dy=0, next position (60,62).
6. WIN_SCORE=2: two P1 misses -> sc2=2, state=4, game_over=1, ball frozen. Then start=1 -> scores cleared, state=SERVE. Separately, assert rst mid-PLAY -> all reset values on the next cycle.
